// File: rtl/text_display.sv
// 80x25 colour text renderer: fetches character/attribute cells and font rows
// ahead of the beam and emits registered 640x400@70Hz VGA with a blinking cursor.
module text_display #(
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 400,
  parameter int V_FP         = 12,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 35,
  parameter int CURSOR_TOP   = 14,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] text_addr,
  input  logic [7:0]  text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [7:0]  cursor_x,
  input  logic [7:0]  cursor_y,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_PREFETCH   = 10'(H_TOTAL - 8);
  localparam logic [9:0]  H_FETCH_END  = 10'(H_VIS - 8);
  localparam logic [9:0]  H_VIS_W      = 10'(H_VIS);
  localparam logic [9:0]  HS_START     = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END       = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [8:0]  V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0]  V_VIS_W      = 9'(V_VIS);
  localparam logic [8:0]  VS_START     = 9'(V_VIS + V_FP);
  localparam logic [8:0]  VS_END       = 9'(V_VIS + V_FP + V_SYNC);
  localparam logic [7:0]  COLS         = 8'(H_VIS / 8);
  localparam logic [7:0]  ROWS         = 8'(V_VIS / 16);
  localparam logic [3:0]  CUR_TOP      = 4'(CURSOR_TOP);
  localparam logic [7:0]  BLINK_LAST   = 8'(BLINK_FRAMES - 1);
  localparam logic [11:0] ROW_BYTES    = 12'd160;

  // The cell for column c is fetched in the 8 clocks before h == 8c; column 0
  // comes from the tail of the previous line.
  function automatic logic fetch_active(input logic [9:0] h);
    return (h < H_FETCH_END) || (h >= H_PREFETCH);
  endfunction

  function automatic logic [6:0] fetch_col(input logic [9:0] h);
    return (h >= H_PREFETCH) ? 7'd0 : 7'(h[9:3] + 7'd1);
  endfunction

  function automatic logic [11:0] colour(input logic [3:0] idx);
    logic [3:0] lo;
    lo = idx[3] ? 4'h5 : 4'h0;
    return {(idx[2] ? 4'hA : 4'h0) + lo,
            (idx[1] ? 4'hA : 4'h0) + lo,
            (idx[0] ? 4'hA : 4'h0) + lo};
  endfunction

  logic [9:0]  h_q, h_d;
  logic [8:0]  v_q, v_d;
  logic [8:0]  fetch_v_q, fetch_v_d;
  logic [11:0] base_q, base_d;
  logic [11:0] text_addr_q, text_addr_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic [7:0]  attr_tmp_q, attr_tmp_d;
  logic [7:0]  glyph_tmp_q, glyph_tmp_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  frame_q, frame_d;
  logic        blink_q, blink_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  logic [8:0]  next_line;
  logic [7:0]  glyph;
  logic        cursor_hit;
  logic [3:0]  pix_idx;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    h_d         = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_d         = v_q;
    fetch_v_d   = fetch_v_q;
    base_d      = base_q;
    text_addr_d = text_addr_q;
    font_addr_d = font_addr_q;
    attr_tmp_d  = attr_tmp_q;
    glyph_tmp_d = glyph_tmp_q;
    shift_d     = {shift_q[6:0], 1'b0};
    attr_d      = attr_q;
    frame_d     = frame_q;
    blink_d     = blink_q;
    next_line   = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
    glyph       = glyph_tmp_q;
    cursor_hit  = 1'b0;

    if (h_q == H_LAST) v_d = next_line;

    // Row base tracks the line being fetched and stops advancing in blanking,
    // keeping addresses within the 4000-byte window.
    if (h_q == H_PREFETCH - 10'd1) begin
      fetch_v_d = next_line;
      if (next_line == 9'd0)
        base_d = 12'd0;
      else if (next_line < V_VIS_W && next_line[3:0] == 4'd0)
        base_d = base_q + ROW_BYTES;
    end

    // Addresses are registered one step early so they line up with phase h_d.
    if (fetch_active(h_d)) begin
      case (h_d[2:0])
        3'd0:    text_addr_d = base_d + {4'd0, fetch_col(h_d), 1'b0};
        3'd1:    text_addr_d = base_d + {4'd0, fetch_col(h_d), 1'b1};
        3'd2:    font_addr_d = {text_data, fetch_v_d[3:0]};
        default: ;
      endcase
    end

    cursor_hit = blink_q && (cursor_x < COLS) && (cursor_y < ROWS) &&
                 (cursor_x == {1'b0, fetch_col(h_q)}) &&
                 (cursor_y == {3'd0, fetch_v_q[8:4]}) &&
                 (fetch_v_q[3:0] >= CUR_TOP);
    if (attr_tmp_q[7] && !blink_q) glyph = 8'h00;
    if (cursor_hit)                glyph = 8'hFF;

    if (fetch_active(h_q)) begin
      case (h_q[2:0])
        3'd2: attr_tmp_d  = text_data;
        3'd3: glyph_tmp_d = font_data;
        3'd7: begin
          shift_d = glyph;
          attr_d  = attr_tmp_q;
        end
        default: ;
      endcase
    end

    if (h_q == H_LAST && v_q == VS_START - 9'd1) begin
      if (frame_q == BLINK_LAST) begin
        frame_d = 8'd0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end

    pix_idx = shift_q[7] ? attr_q[3:0] : {1'b0, attr_q[6:4]};
    rgb_d   = (h_q < H_VIS_W && v_q < V_VIS_W) ? colour(pix_idx) : 12'h000;
    hs_d    = !(h_q >= HS_START && h_q < HS_END);
    vs_d    = (v_q >= VS_START && v_q < VS_END);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      fetch_v_q   <= '0;
      base_q      <= '0;
      text_addr_q <= '0;
      font_addr_q <= '0;
      attr_tmp_q  <= '0;
      glyph_tmp_q <= '0;
      shift_q     <= '0;
      attr_q      <= '0;
      frame_q     <= '0;
      blink_q     <= 1'b1;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      fetch_v_q   <= fetch_v_d;
      base_q      <= base_d;
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      attr_tmp_q  <= attr_tmp_d;
      glyph_tmp_q <= glyph_tmp_d;
      shift_q     <= shift_d;
      attr_q      <= attr_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign r         = rgb_q[11:8];
  assign g         = rgb_q[7:4];
  assign b         = rgb_q[3:0];
  assign hs        = hs_q;
  assign vs        = vs_q;

endmodule

// File: tb/tb_text_display.sv
// Scoreboard bench for text_display with a shortened vertical frame (54 lines)
// and one-frame blink so blink, cursor and frame wrap fit in a short run.
module tb_text_display;

  localparam int FRAME = 54 * 800;
  localparam int K_RGB = 0, K_HS = 1, K_VS = 2, K_TA = 3, K_FA = 4;

  logic        clock, reset;
  logic [11:0] text_addr, font_addr;
  logic [7:0]  text_data, font_data;
  logic [7:0]  cursor_x, cursor_y;
  logic [3:0]  r, g, b;
  logic        hs, vs;

  text_display #(
    .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(2), .BLINK_FRAMES(1)
  ) dut (
    .clock(clock), .reset(reset),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] tmem [0:4095];
  logic [7:0] fmem [0:4095];
  always @(posedge clock) begin
    text_data <= tmem[text_addr];
    font_data <= fmem[font_addr];
  end

  int cyc;
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    checks, passed;
  logic  done;

  task automatic push(input int c, input int kind, input logic [11:0] exp, input string name);
    item_t it;
    it.cyc = c; it.kind = kind; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask

  // Eight pixels of one cell: glyph bit set -> fg colour, else bg colour.
  task automatic push_cell(input int f, input int v, input int col, input logic [7:0] glyph,
                           input logic [11:0] fg, input logic [11:0] bg, input string name);
    for (int i = 0; i < 8; i++)
      push(f * FRAME + v * 800 + col * 8 + i + 1, K_RGB, glyph[7-i] ? fg : bg, name);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares the DUT against the head of the scoreboard at its cycle.
  always @(negedge clock) begin
    item_t       it;
    logic [11:0] act;
    if (done) begin
      check("scoreboard_drained", 12'(sb.size()), 12'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end else if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        case (it.kind)
          K_RGB:   act = {r, g, b};
          K_HS:    act = {11'd0, hs};
          K_VS:    act = {11'd0, vs};
          K_TA:    act = text_addr;
          default: act = font_addr;
        endcase
        if (it.cyc != cyc) begin
          checks++;
          $display("FAIL %s: sampled at cycle %0d, required cycle %0d", it.name, cyc, it.cyc);
        end else begin
          check(it.name, act, it.exp);
        end
      end
    end
  end

  task automatic push_after_reset(input string tag);
    push(0, K_RGB, 12'h000, {tag, "_rgb"});
    push(0, K_HS,  12'd1,   {tag, "_hs"});
    push(0, K_VS,  12'd0,   {tag, "_vs"});
    push(0, K_TA,  12'd0,   {tag, "_text_addr"});
    push(0, K_FA,  12'd0,   {tag, "_font_addr"});
    push(656, K_HS, 12'd1, {tag, "_hs_before_fall"});
    push(657, K_HS, 12'd0, {tag, "_hs_fall"});
  endtask

  initial begin
    reset = 1'b1;
    cursor_x = 8'd80;
    cursor_y = 8'd1;
    done = 1'b0;
    checks = 0;
    passed = 0;
    for (int i = 0; i < 4096; i++) begin
      tmem[i] = 8'h00;
      fmem[i] = 8'h00;
    end
    tmem[0]   = 8'h41; tmem[1]   = 8'h1E;   // cell (0,0)
    fmem[12'h410] = 8'h81;
    tmem[10]  = 8'h44; tmem[11]  = 8'h87;   // blinking cell (0,5)
    fmem[12'h441] = 8'hF0;
    tmem[159] = 8'h70;                      // cell (0,79): grey background
    tmem[160] = 8'h42;                      // cell (1,0)
    tmem[166] = 8'h43; tmem[167] = 8'h07;   // cell (1,3)
    tmem[326] = 8'h43; tmem[327] = 8'h07;   // cell (2,3)
    tmem[479] = 8'h70;                      // cell (2,79)
    fmem[12'h43D] = 8'h3C;
    fmem[12'h43F] = 8'h18;

    push_after_reset("reset");
    push(752, K_HS, 12'd0, "hs_last_low");
    push(753, K_HS, 12'd1, "hs_rise");
    push_cell(0, 1, 5, 8'hF0, 12'hAAA, 12'h000, "blink_shown_f0");
    push(800 + 639 + 1, K_RGB, 12'hAAA, "last_visible_px");
    push(800 + 640 + 1, K_RGB, 12'h000, "hblank_px");
    push(1456, K_HS, 12'd1, "hs_period_before");
    push(1457, K_HS, 12'd0, "hs_period_fall");
    push(15 * 800 + 792, K_TA, 12'd160, "prefetch_char_addr");
    push(15 * 800 + 793, K_TA, 12'd161, "prefetch_attr_addr");
    push(15 * 800 + 794, K_FA, 12'h420, "prefetch_font_addr");
    push_cell(0, 30, 3, 8'h00, 12'hAAA, 12'h000, "no_cursor_x80_row14");
    push_cell(0, 31, 3, 8'h18, 12'hAAA, 12'h000, "no_cursor_x80_row15");
    push_cell(0, 45, 3, 8'h3C, 12'hAAA, 12'h000, "cursor_row13_glyph");
    push_cell(0, 46, 3, 8'hFF, 12'hAAA, 12'h000, "cursor_row14");
    push_cell(0, 47, 3, 8'hFF, 12'hAAA, 12'h000, "cursor_row15");
    push(47 * 800 + 635 + 1, K_RGB, 12'hAAA, "last_visible_line_px");
    push(48 * 800 + 635 + 1, K_RGB, 12'h000, "vblank_px");
    push(49 * 800 + 800, K_VS, 12'd0, "vs_before");
    push(50 * 800 + 1,   K_VS, 12'd1, "vs_start");
    push(51 * 800 + 800, K_VS, 12'd1, "vs_last_high");
    push(52 * 800 + 1,   K_VS, 12'd0, "vs_end");
    push_cell(1, 0, 0, 8'h81, 12'hFF5, 12'h00A, "cell00_colour");
    push_cell(1, 1, 5, 8'h00, 12'hAAA, 12'h000, "blink_hidden_f1");

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    wait_cyc(35 * 800);
    cursor_x = 8'd3;
    cursor_y = 8'd2;

    // One-clock reset in the middle of line 4 of frame 1.
    wait_cyc(FRAME + 4 * 800 + 300);
    reset = 1'b1;
    @(posedge clock);
    #1;
    push_after_reset("midreset");
    push_cell(0, 1, 5, 8'hF0, 12'hAAA, 12'h000, "blink_phase_reset");
    reset = 1'b0;

    wait_cyc(900);
    done = 1'b1;
  end

endmodule
